fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of one sync_fifo_1w1r instance between NREQ requesters.
- Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's push/wr_data.
- It never pushes while the FIFO reports full.
- It sits between the producer agents and the shared FIFO.

Parameters:
- NREQ, 4: number of requesters. Legal range 2..16.
- DATA_WIDTH, 32: width of each requester's data word and of fifo_wr_data.
- MAX_BURST, 4: maximum beats accepted from one requester per grant. Legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NREQ  per-requester accept. At most one bit is set at any time.
- fifo_full  in  1  full flag from the FIFO.
- fifo_push  out  1  push strobe to the FIFO.
- fifo_wr_data  out  DATA_WIDTH  write data to the FIFO.
- grant_id  out  $clog2(NREQ)  index of the current grantee.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, req_ready=0, fifo_push=0, fifo_wr_data=0, busy=0. Reset asserted mid-burst aborts the burst immediately; no push occurs in a reset cycle.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - req_ready=0 and fifo_push=0.
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Register the selection into grant_id, clear beat_cnt, and move to GRANT.
  - Arbitration latency is 1 cycle from req_valid to req_ready.
- GRANT (g = grant_id):
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_push = req_valid[g] & ~fifo_full (combinational).
  - fifo_wr_data = req_data slice g when pushing, otherwise 0.
  - A beat is any cycle with fifo_push=1. Each beat increments beat_cnt (8-bit).
- Release from GRANT to IDLE, with rr_ptr <= (g+1) mod NREQ, when either:
  - (a) a beat occurs and beat_cnt == MAX_BURST-1, or
  - (b) req_valid[g]==0 in any GRANT cycle, including the very first GRANT cycle (zero-beat grant).
- Each release costs exactly one IDLE bubble cycle before the next grant. Burst throughput is 1 beat/cycle while not full.
- fifo_full=1 in GRANT stalls the burst:
  - no push, beat_cnt holds, grant held;
  - a stall never causes a release unless req_valid[g] also drops.
- Requesters must hold req_data stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- Requests from non-granted requesters are ignored until the next IDLE. A requester that deasserts and reasserts valid gets no priority change.
- MAX_BURST=1: every beat releases; each requester pushes at most 1 beat per 2 cycles.
- Single active requester: it is re-granted after each release bubble; rr_ptr wraps past it and back.
- grant_id holds its last value in IDLE until the next grant. busy = (state==GRANT).
- Invariant (checked in bench): fifo_push implies ~fifo_full.

Test Plan:
- Single requester, no backpressure. NREQ=4, MAX_BURST=4; req_valid=4'b0010 with data 0x10..0x17. Expected: grant_id=1; beats 0x10-0x13 on 4 consecutive cycles; 1 IDLE bubble; 0x14-0x17. No other req_ready bits set.
- Round robin. All 4 requesters valid continuously, 4 beats each. Expected: grant order 0,1,2,3,0...; exactly 4 pushes per grant; bubble between grants; 16 pushes + 4 bubbles in 20 cycles after the first grant.
- Full backpressure. Requester 2 is granted; fifo_full=1 for 3 cycles after beat 2. Expected: no push and req_ready[2]=0 during the stall; beat_cnt stays 2; beats 3-4 follow the stall; then release.
- Early drop. Requester 0 pushes 2 beats, then drops valid while requester 3 is valid. Expected: release with 2 beats; next grant_id=3 (not 1 or 2 unless valid); rr_ptr=1 after the release.
- Zero-beat grant and MAX_BURST=1. Requester pulses valid for only the IDLE cycle: grant, then immediate release with fifo_push never high. Separately with MAX_BURST=1, requesters 0 and 1 always valid: pushes alternate 0,1,0,1 every 2 cycles.
- Async reset mid-burst. Assert rst between clock edges during beat 2. Expected: fifo_push, req_ready and busy go to 0 immediately. After release of reset the first grant goes to requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ valid/ready requesters.
// A grant lasts until MAX_BURST beats are pushed or the grantee drops valid.
module fifo_wr_arbiter #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   output logic [NREQ-1:0]            req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_push,
   output logic [DATA_WIDTH-1:0]      fifo_wr_data,
   output logic [$clog2(NREQ)-1:0]    grant_id,
   output logic                       busy
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   grant_id_q, grant_id_d;
   logic [7:0]      beat_cnt_q, beat_cnt_d;
   logic [IW-1:0]   sel_idx;
   logic [IW-1:0]   next_ptr;
   logic            cur_valid;
   logic            push;
   logic            last_beat;

   // Scan downward so the candidate closest to rr_ptr is the last one written.
   always_comb begin
      logic [IW-1:0] cand;
      sel_idx = '0;
      cand    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IW'((int'(rr_ptr_q) + k) % NREQ);
         if (req_valid[cand]) sel_idx = cand;
      end
   end

   assign cur_valid = req_valid[grant_id_q];
   assign push      = (state_q == GRANT) && cur_valid && !fifo_full;
   assign last_beat = (beat_cnt_q == 8'(MAX_BURST - 1));
   assign next_ptr  = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d    = GRANT;
               grant_id_d = sel_idx;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (push) beat_cnt_d = beat_cnt_q + 8'd1;
            // A full FIFO only stalls; release needs a final beat or a dropped valid.
            if (!cur_valid || (push && last_beat)) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == GRANT) req_ready[grant_id_q] = !fifo_full;
   end

   assign fifo_push    = push;
   assign fifo_wr_data = push ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign grant_id     = grant_id_q;
   assign busy         = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester producers, expected-push scoreboard.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;

   logic                 clk, rst;
   logic [NREQ-1:0]      req_valid, req_ready, req_valid1, req_ready1;
   logic [NREQ*DW-1:0]   req_data, req_data1;
   logic                 fifo_full, full1, fifo_push, fifo_push1, busy, busy1;
   logic [DW-1:0]        fifo_wr_data, fifo_wr_data1;
   logic [1:0]           grant_id, grant_id1;

   fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
      .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy));

   fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1),
      .req_ready(req_ready1), .fifo_full(full1), .fifo_push(fifo_push1),
      .fifo_wr_data(fifo_wr_data1), .grant_id(grant_id1), .busy(busy1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   int          pushcyc[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          remaining[NREQ];
   logic [31:0] nextd[NREQ];

   logic        s_push, s_busy, s_push1;
   logic [3:0]  s_ready;
   logic [1:0]  s_gid, s_rr, s_gid1;
   logic [31:0] s_data1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]          = (remaining[i] > 0);
         req_data[i*DW +: DW]  = nextd[i];
      end
   endtask

   task automatic expect_beats(input int id, input logic [31:0] base, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.id   = 2'(id);
         e.data = base + 32'(k);
         q.push_back(e);
      end
   endtask

   // One clock: sample and score at negedge, then advance producers after posedge.
   task automatic step();
      logic [NREQ-1:0] acc;
      exp_t e;
      @(negedge clk);
      acc     = req_valid & req_ready;
      s_push  = fifo_push;
      s_busy  = busy;
      s_ready = req_ready;
      s_gid   = grant_id;
      s_rr    = dut.rr_ptr_q;
      s_push1 = fifo_push1;
      s_gid1  = grant_id1;
      s_data1 = fifo_wr_data1;
      if (req_ready != '0) chk("ready_at_grant", 32'(req_ready), 32'(1) << grant_id);
      if (fifo_push) begin
         chk("push_while_full", 32'(fifo_full), 32'(0));
         total++;
         assert (q.size() > 0) else begin
            bad++;
            $error("FAIL unexpected_push obs=%0h exp=none", fifo_wr_data);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("push_data", fifo_wr_data, e.data);
            chk("push_id", 32'(grant_id), 32'(e.id));
         end
         pushcyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NREQ; i++)
         if (acc[i]) begin
            remaining[i]--;
            nextd[i]++;
         end
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) remaining[i] = 0;
      drive();
      q.delete();
      pushcyc.delete();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_drained"}, 32'(q.size()), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst        = 1'b1;
      fifo_full  = 1'b0;
      full1      = 1'b0;
      req_valid1 = '0;
      req_data1  = '0;
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 0;
         nextd[i]     = '0;
      end
      drive();
      step();
      step();
      chk("reset_ready", 32'(req_ready), 32'(0));
      chk("reset_push", 32'(fifo_push), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_gid", 32'(grant_id), 32'(0));
      chk("reset_wdata", fifo_wr_data, 32'(0));
      rst = 1'b0;

      // single requester, two bursts separated by one bubble
      pushcyc.delete();
      remaining[1] = 8;
      nextd[1]     = 32'h10;
      drive();
      c0 = cyc;
      expect_beats(1, 32'h10, 8);
      drain("t1", 30);
      chk("t1_count", 32'(pushcyc.size()), 32'(8));
      if (pushcyc.size() == 8) begin
         chk("t1_latency", pushcyc[0], c0 + 1);
         for (int k = 1; k < 8; k++) chk("t1_gap", pushcyc[k] - pushcyc[k-1], (k == 4) ? 2 : 1);
      end

      // round robin over all four
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 4;
         nextd[i]     = 32'h100 * (i + 1);
         expect_beats(i, 32'h100 * (i + 1), 4);
      end
      drive();
      drain("t2", 40);
      chk("t2_count", 32'(pushcyc.size()), 32'(16));
      if (pushcyc.size() == 16) begin
         chk("t2_span", pushcyc[15] - pushcyc[0], 18);
         for (int k = 1; k < 16; k++) chk("t2_gap", pushcyc[k] - pushcyc[k-1], (k % 4 == 0) ? 2 : 1);
      end

      // backpressure after beat 2
      do_reset();
      remaining[2] = 4;
      nextd[2]     = 32'h200;
      drive();
      expect_beats(2, 32'h200, 4);
      step();
      step();
      step();
      fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t3_stall_push", 32'(s_push), 32'(0));
         chk("t3_stall_ready", 32'(s_ready), 32'(0));
         chk("t3_stall_busy", 32'(s_busy), 32'(1));
         chk("t3_stall_gid", 32'(s_gid), 32'(2));
      end
      fifo_full = 1'b0;
      drain("t3", 10);
      chk("t3_count", 32'(pushcyc.size()), 32'(4));
      if (pushcyc.size() == 4) chk("t3_stall_gap", pushcyc[2] - pushcyc[1], 4);
      step();
      chk("t3_released", 32'(s_busy), 32'(0));

      // early drop by requester 0, next grant skips idle 1 and 2
      do_reset();
      remaining[0] = 2;
      nextd[0]     = 32'h0;
      remaining[3] = 4;
      nextd[3]     = 32'h300;
      drive();
      expect_beats(0, 32'h0, 2);
      expect_beats(3, 32'h300, 4);
      repeat (4) step();
      chk("t4_drop_nopush", 32'(s_push), 32'(0));
      chk("t4_drop_busy", 32'(s_busy), 32'(1));
      step();
      chk("t4_idle_busy", 32'(s_busy), 32'(0));
      chk("t4_rr_ptr", 32'(s_rr), 32'(1));
      drain("t4", 20);
      if (pushcyc.size() == 6) chk("t4_gap", pushcyc[2] - pushcyc[1], 3);
      else chk("t4_count", 32'(pushcyc.size()), 32'(6));

      // zero-beat grant
      do_reset();
      remaining[1] = 1;
      nextd[1]     = 32'h55;
      drive();
      step();
      remaining[1] = 0;
      drive();
      step();
      chk("t5_zb_busy", 32'(s_busy), 32'(1));
      chk("t5_zb_gid", 32'(s_gid), 32'(1));
      chk("t5_zb_push", 32'(s_push), 32'(0));
      step();
      chk("t5_zb_release", 32'(s_busy), 32'(0));
      chk("t5_zb_rr", 32'(s_rr), 32'(2));

      // MAX_BURST=1 instance: 0 and 1 alternate, one push every 2 cycles
      req_valid1         = 4'b0011;
      req_data1[0 +: DW] = 32'hA0;
      req_data1[DW +: DW] = 32'hB1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t5_mb1_push", 32'(s_push1), 32'(k % 2 == 0));
         if (k % 2 == 0) begin
            chk("t5_mb1_gid", 32'(s_gid1), 32'(((k / 2) - 1) % 2));
            chk("t5_mb1_data", s_data1, (((k / 2) - 1) % 2 == 1) ? 32'hB1 : 32'hA0);
         end
      end
      req_valid1 = '0;

      // async reset during beat 2
      do_reset();
      remaining[0] = 4;
      nextd[0]     = 32'h400;
      drive();
      expect_beats(0, 32'h400, 1);
      step();
      step();
      #2;
      chk("t6_pre_push", 32'(fifo_push), 32'(1));
      rst = 1'b1;
      #1;
      chk("t6_rst_push", 32'(fifo_push), 32'(0));
      chk("t6_rst_ready", 32'(req_ready), 32'(0));
      chk("t6_rst_busy", 32'(busy), 32'(0));
      chk("t6_rst_gid", 32'(grant_id), 32'(0));
      chk("t6_rst_wdata", fifo_wr_data, 32'(0));
      remaining[1] = 4;
      nextd[1]     = 32'h500;
      drive();
      step();
      rst = 1'b0;
      chk("t6_beat1_only", 32'(q.size()), 32'(0));
      expect_beats(0, 32'h401, 3);
      expect_beats(1, 32'h500, 4);
      drain("t6", 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
